// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexes one external XNOR-popcount neuron across a BNN layer: latches an input
// vector, streams weight/threshold words from a 1-cycle ROM and collects one bit per neuron.
module bnn_layer_sequencer #(
  parameter int INPUT_SIZE      = 10,
  parameter int NUM_NEURONS     = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int THRESHOLD_WIDTH = 4,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_SIZE-1:0]      in_vec,
  output logic                       w_rd_en,
  output logic [ADDR_WIDTH-1:0]      w_addr,
  input  logic [INPUT_SIZE-1:0]      w_data,
  input  logic [THRESHOLD_WIDTH-1:0] th_data,
  output logic [INPUT_SIZE-1:0]      neu_in,
  output logic [INPUT_SIZE-1:0]      neu_weight,
  output logic [THRESHOLD_WIDTH-1:0] neu_threshold,
  input  logic                       neu_out,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_NEURONS-1:0]     out_vec,
  output logic [CNT_WIDTH-1:0]       ones_count,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_NEURONS - 1);

  state_t                   state_q;
  logic [INPUT_SIZE-1:0]    in_vec_q;
  logic [NUM_NEURONS-1:0]   out_vec_q, out_vec_d;
  logic [CNT_WIDTH-1:0]     ones_q, ones_d;
  logic [ADDR_WIDTH-1:0]    issue_q;
  logic [ADDR_WIDTH-1:0]    eval_q;
  logic                     eval_vld_q;
  logic                     rd_en_q;
  logic                     out_valid_q;
  logic                     capture;

  // ROM data returned this cycle belongs to the neuron issued one cycle earlier (eval_q).
  always_comb begin
    out_vec_d = out_vec_q;
    ones_d    = ones_q;
    capture   = ((state_q == RUN) && eval_vld_q) || (state_q == DRAIN);
    if (capture) begin
      out_vec_d[eval_q] = neu_out;
      if (neu_out) ones_d = ones_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_vec_q    <= '0;
      out_vec_q   <= '0;
      ones_q      <= '0;
      issue_q     <= '0;
      eval_q      <= '0;
      eval_vld_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      out_vec_q   <= '0;
      ones_q      <= '0;
      issue_q     <= '0;
      eval_q      <= '0;
      eval_vld_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_vec_q   <= in_vec;
            out_vec_q  <= '0;
            ones_q     <= '0;
            issue_q    <= '0;
            eval_q     <= '0;
            eval_vld_q <= 1'b0;
            rd_en_q    <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          out_vec_q  <= out_vec_d;
          ones_q     <= ones_d;
          eval_q     <= issue_q;
          eval_vld_q <= 1'b1;
          if (issue_q == LastIdx) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            issue_q <= issue_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          out_vec_q   <= out_vec_d;
          ones_q      <= ones_d;
          eval_vld_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign w_rd_en       = rd_en_q;
  assign w_addr        = issue_q;
  assign neu_in        = in_vec_q;
  assign neu_weight    = w_data;
  assign neu_threshold = th_data;
  assign out_valid     = out_valid_q;
  assign out_vec       = out_vec_q;
  assign ones_count    = ones_q;

endmodule
